softmax_scheduler: RTL and testbench

Shares one softmax unit between NUM_REQ inference lanes. Each lane submits a 10-logit vector. The block grants lanes round-robin and holds the vector stable on the unit's input. It resets the unit before every job, launches it, waits for completion, then computes the argmax class. It returns probabilities plus class to the granted lane over a valid/ready response channel. It sits between the final dense layer instances and the classification output.

---
 rtl/softmax_pkg.sv | 16 +
 rtl/softmax_scheduler_rr_arbiter.sv | 31 +++
 rtl/softmax_scheduler.sv | 154 +++++++++++++++
 tb/tb_softmax_scheduler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax scheduler slice.
package softmax_pkg;
    localparam int         LANES           = 10;
    localparam int         DW              = 16;
    localparam logic [3:0] CLASS_NONE      = 4'hF;
    localparam int         DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LAUNCH,
        WAIT,
        ARGMAX,
        RESP
    } sched_state_t;
endpackage

// File: rtl/softmax_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    int            cand;
    logic [IW-1:0] sel;

    // Walk from the farthest candidate to the nearest so the lane right after
    // the previous winner overrides any other hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        sel       = '0;
        for (int k = N; k >= 1; k--) begin
            cand = (int'(last) + k) % N;
            sel  = IW'(cand);
            if (req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end
endmodule

// File: rtl/softmax_scheduler.sv
// Shares one softmax unit between NUM_REQ lanes and returns probs plus argmax class.
// Optional watchdog: define SOFTMAX_SCHED_WATCHDOG_EN to abort stalled jobs after TIMEOUT WAIT cycles.
module softmax_scheduler
    import softmax_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int LANES   = softmax_pkg::LANES,
    parameter int DW      = softmax_pkg::DW,
    parameter int TIMEOUT = softmax_pkg::DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*LANES*DW-1:0] req_logits,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [LANES*DW-1:0]         rsp_probs,
    output logic [3:0]                  rsp_class,
    output logic                        rsp_err,
    output logic                        sm_rst,
    output logic                        sm_in_valid,
    output logic [LANES*DW-1:0]         sm_logits,
    input  logic [LANES*DW-1:0]         sm_probs,
    input  logic                        sm_out_valid
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int VW = LANES * DW;

    sched_state_t         state, state_next;
    logic [GW-1:0]        last_grant, grant_lane;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [GW-1:0]        arb_idx;
    logic                 accept, timeout, cur_wins, last_lane;
    logic [3:0]           idx, best_idx;
    logic signed [DW-1:0] best, cur;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .last      (last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign accept      = (state == IDLE) && !rst && (|req_valid);
    assign req_ready   = accept ? arb_grant : '0;
    assign rsp_valid   = (state == RESP) ? (NUM_REQ'(1) << grant_lane) : '0;
    assign sm_rst      = rst || (state == CLR);
    assign sm_in_valid = (state == LAUNCH);

    assign cur       = rsp_probs[int'(idx)*DW +: DW];
    assign cur_wins  = cur > best;
    assign last_lane = (idx == 4'(LANES - 1));

`ifdef SOFTMAX_SCHED_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == LAUNCH)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (accept)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end

    // Fires in the WAIT cycle whose increment would make the count reach TIMEOUT.
    assign timeout = (state == WAIT) && !sm_out_valid && (wait_cnt == CW'(TIMEOUT - 1));
    assign rsp_err = err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CLR;
            CLR:     state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT: begin
                if (sm_out_valid)
                    state_next = ARGMAX;
                else if (timeout)
                    state_next = RESP;
            end
            ARGMAX:  if (last_lane) state_next = RESP;
            RESP:    if (rsp_ready[grant_lane]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant_lane <= '0;
            sm_logits  <= '0;
            rsp_probs  <= '0;
            rsp_class  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_lane <= arb_idx;
                        sm_logits  <= req_logits[int'(arb_idx)*VW +: VW];
                    end
                end
                WAIT: begin
                    if (sm_out_valid) begin
                        rsp_probs <= sm_probs;
                    end else if (timeout) begin
                        rsp_probs <= '0;
                        rsp_class <= CLASS_NONE;
                    end
                end
                ARGMAX: begin
                    if (last_lane)
                        rsp_class <= cur_wins ? idx : best_idx;
                end
                RESP: begin
                    if (rsp_ready[grant_lane])
                        last_grant <= grant_lane;
                end
                default: ;
            endcase
        end
    end

    // Argmax scratch: seeded with the most negative value, strict compare keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (state == WAIT) begin
            idx      <= '0;
            best     <= {1'b1, {(DW-1){1'b0}}};
            best_idx <= '0;
        end else if (state == ARGMAX) begin
            idx <= idx + 1'b1;
            if (cur_wins) begin
                best     <= cur;
                best_idx <= idx;
            end
        end
    end
endmodule

// File: tb/tb_softmax_scheduler.sv
// Self-checking bench for softmax_scheduler with a programmable-latency softmax unit stub.
module tb_softmax_scheduler;
    localparam int NUM_REQ = 2;
    localparam int LANES   = 10;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;
    localparam int VW      = LANES * DW;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ*VW-1:0]    req_logits;
    logic [VW-1:0]            rsp_probs, sm_logits, sm_probs;
    logic [3:0]               rsp_class;
    logic                     rsp_err, sm_rst, sm_in_valid, sm_out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rr_last  = NUM_REQ - 1;

    int            stub_lat = 46;
    logic [VW-1:0] stub_probs;
    int            stub_cnt;
    logic          stub_busy;

    int   rst_cyc = -1, launch_cyc = -1, w_cyc = -1;
    logic ov_prev = 1'b0;

    softmax_scheduler #(
        .NUM_REQ (NUM_REQ),
        .LANES   (LANES),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_logits   (req_logits),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_probs    (rsp_probs),
        .rsp_class    (rsp_class),
        .rsp_err      (rsp_err),
        .sm_rst       (sm_rst),
        .sm_in_valid  (sm_in_valid),
        .sm_logits    (sm_logits),
        .sm_probs     (sm_probs),
        .sm_out_valid (sm_out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unit stub: done level rises stub_lat cycles after launch, cleared only by sm_rst; stub_lat==0 never finishes.
    always @(posedge clk) begin
        if (sm_rst) begin
            sm_out_valid <= 1'b0;
            stub_busy    <= 1'b0;
            stub_cnt     <= 0;
        end else if (sm_in_valid) begin
            stub_busy <= 1'b1;
            stub_cnt  <= 1;
        end else if (stub_busy && stub_lat > 0) begin
            if (stub_cnt >= stub_lat - 1) begin
                sm_out_valid <= 1'b1;
                stub_busy    <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end
    assign sm_probs = stub_probs;

    always @(negedge clk) begin
        if (sm_rst && !rst) rst_cyc = cyc;
        if (sm_in_valid) launch_cyc = cyc;
        if (sm_out_valid === 1'b1 && !ov_prev) w_cyc = cyc;
        ov_prev = (sm_out_valid === 1'b1);
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference: the class is the first lane holding the maximum signed value.
    function automatic int ref_argmax(input logic [VW-1:0] p);
        int mx = -40000;
        for (int i = 0; i < LANES; i++) begin
            int v = $signed(p[i*DW +: DW]);
            if (v > mx) mx = v;
        end
        for (int i = 0; i < LANES; i++) begin
            int v = $signed(p[i*DW +: DW]);
            if (v == mx) return i;
        end
        return 0;
    endfunction

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] reqs);
        for (int k = 1; k <= NUM_REQ; k++)
            if (reqs[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Drives one job on a lane and returns what the response channel showed.
    task automatic run_job(input int lane, input logic [VW-1:0] logits,
                           output int t_acc, output int t_rsp, output logic [VW-1:0] probs,
                           output logic [3:0] cls, output logic err, output bit ok);
        int n;
        ok = 1'b0; t_acc = -1; t_rsp = -1; probs = '0; cls = '0; err = 1'b0;
        req_logits[lane*VW +: VW] = logits;
        req_valid[lane] = 1'b1;
        n = 0;
        while (n < 200) begin
            #1;
            if (req_ready[lane]) break;
            step();
            n++;
        end
        if (n == 200) begin
            req_valid[lane] = 1'b0;
            return;
        end
        t_acc = cyc;
        step();
        req_valid[lane] = 1'b0;
        n = 0;
        while (n < 1000 && !rsp_valid[lane]) begin
            step();
            n++;
        end
        if (n == 1000) return;
        t_rsp = cyc;
        probs = rsp_probs;
        cls   = rsp_class;
        err   = rsp_err;
        rsp_ready[lane] = 1'b1;
        step();
        rsp_ready[lane] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        step();
        step();
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_probs !== '0 || rsp_class !== 4'd0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp_data: probs %h class %h err %b want zeros", rsp_probs, rsp_class, rsp_err); end
        n_checks++; if (sm_in_valid !== 1'b0 || sm_logits !== '0) begin
            n_fail++; $display("FAIL reset_sm_outputs: in_valid %b logits %h want zeros", sm_in_valid, sm_logits); end
        n_checks++; if (sm_rst !== 1'b1) begin n_fail++; $display("FAIL reset_sm_rst: got %b want 1", sm_rst); end
        req_valid = '0;
        rst = 1'b0;
        step();
        n_checks++; if (sm_rst !== 1'b0) begin n_fail++; $display("FAIL idle_sm_rst: got %b want 0", sm_rst); end
        rr_last = NUM_REQ - 1;
    endtask

    task automatic test_single();
        logic [VW-1:0] lg, pr;
        int ta, tr;
        logic [3:0] cls;
        logic err;
        bit ok;
        stub_lat = 46;
        lg = '0;
        lg[7*DW +: DW] = 16'h1000;
        for (int i = 0; i < LANES; i++) stub_probs[i*DW +: DW] = (i == 7) ? 16'h4000 : 16'h0800;
        run_job(0, lg, ta, tr, pr, cls, err, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_handshake: got no response want one"); end
        n_checks++; if (rst_cyc !== ta + 1) begin n_fail++; $display("FAIL single_sm_rst_cycle: got %0d want %0d", rst_cyc, ta + 1); end
        n_checks++; if (launch_cyc !== ta + 2) begin n_fail++; $display("FAIL single_launch_cycle: got %0d want %0d", launch_cyc, ta + 2); end
        n_checks++; if (tr !== w_cyc + 11) begin n_fail++; $display("FAIL single_rsp_cycle: got %0d want %0d", tr, w_cyc + 11); end
        n_checks++; if (cls !== 4'd7) begin n_fail++; $display("FAIL single_class: got %0d want 7", cls); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", err); end
        n_checks++; if (pr !== stub_probs) begin n_fail++; $display("FAIL single_probs: got %h want %h", pr, stub_probs); end
        n_checks++; if (sm_logits !== lg) begin n_fail++; $display("FAIL single_sm_logits: got %h want %h", sm_logits, lg); end
        rr_last = 0;
    endtask

    task automatic test_round_robin();
        logic [VW-1:0] lane_lg [NUM_REQ];
        logic [NUM_REQ-1:0] want;
        int g, prev_g, exp, n;
        prev_g = -1;
        stub_lat = 46;
        stub_probs = rand_vec();
        for (int l = 0; l < NUM_REQ; l++) begin
            lane_lg[l] = rand_vec();
            req_logits[l*VW +: VW] = lane_lg[l];
        end
        req_valid = '1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (n < 200) begin
                #1;
                if (|req_ready) break;
                step();
                n++;
            end
            exp  = rr_pick(rr_last, req_valid);
            want = NUM_REQ'(1) << exp;
            n_checks++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", j, req_ready, want); end
            g = exp;
            for (int l = 0; l < NUM_REQ; l++) if (req_ready[l]) g = l;
            n_checks++; if (g == prev_g) begin n_fail++; $display("FAIL rr_repeat_%0d: got lane %0d twice want alternation", j, g); end
            prev_g = g;
            step();
            n_checks++; if (sm_logits !== lane_lg[g]) begin n_fail++; $display("FAIL rr_capture_%0d: got %h want %h", j, sm_logits, lane_lg[g]); end
            lane_lg[g] = rand_vec();
            req_logits[g*VW +: VW] = lane_lg[g];
            n = 0;
            while (n < 1000 && !rsp_valid[g]) begin
                step();
                n++;
            end
            n_checks++; if (launch_cyc - rst_cyc !== 1) begin n_fail++; $display("FAIL rr_rst_to_launch_%0d: got %0d want 1", j, launch_cyc - rst_cyc); end
            n_checks++; if (rsp_class !== 4'(ref_argmax(stub_probs)) || rsp_valid !== want) begin
                n_fail++; $display("FAIL rr_response_%0d: valid %b class %0d want %b class %0d", j, rsp_valid, rsp_class, want, ref_argmax(stub_probs)); end
            rsp_ready[g] = 1'b1;
            step();
            rsp_ready[g] = 1'b0;
            rr_last = g;
            stub_probs = rand_vec();
        end
        req_valid = '0;
        // A grant may have been taken in the last step; let it finish.
        n = 0;
        while (n < 1000 && rsp_valid == '0 && dut.state != softmax_pkg::IDLE) begin
            step();
            n++;
        end
        if (rsp_valid != '0) begin
            for (int l = 0; l < NUM_REQ; l++) if (rsp_valid[l]) rr_last = l;
            rsp_ready = rsp_valid;
            step();
            rsp_ready = '0;
        end
    endtask

    task automatic test_tie();
        logic [VW-1:0] pr;
        int ta, tr;
        logic [3:0] cls;
        logic err;
        bit ok;
        for (int i = 0; i < LANES; i++) stub_probs[i*DW +: DW] = 16'($urandom_range(0, 16'h5FFF) - 16'h3000);
        stub_probs[2*DW +: DW] = 16'h3000;
        stub_probs[5*DW +: DW] = 16'h3000;
        stub_lat = $urandom_range(2, 50);
        run_job(1, rand_vec(), ta, tr, pr, cls, err, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tie_handshake: got no response want one"); end
        n_checks++; if (cls !== 4'd2 || cls !== 4'(ref_argmax(stub_probs))) begin n_fail++; $display("FAIL tie_class: got %0d want 2", cls); end
        rr_last = 1;
    endtask

    task automatic test_stall_back_to_back();
        logic [VW-1:0] exp_probs;
        int n;
        bit stable_bad, ready1_bad;
        stub_lat = 30;
        stub_probs = rand_vec();
        exp_probs = stub_probs;
        req_logits[0 +: VW] = rand_vec();
        req_valid = 2'b01;
        n = 0;
        while (n < 200) begin
            #1;
            if (req_ready[0]) break;
            step();
            n++;
        end
        step();
        req_valid = 2'b10;
        n = 0;
        while (n < 1000 && !rsp_valid[0]) begin
            step();
            n++;
        end
        n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL stall_first_rsp: got %b want 01", rsp_valid); end
        stable_bad = 1'b0;
        ready1_bad = 1'b0;
        rsp_ready = 2'b10;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid !== 2'b01 || rsp_probs !== exp_probs || rsp_class !== 4'(ref_argmax(exp_probs))) stable_bad = 1'b1;
            if (req_ready[1] !== 1'b0) ready1_bad = 1'b1;
            step();
        end
        n_checks++; if (stable_bad) begin n_fail++; $display("FAIL stall_stable: got changing response want held valid=01 probs/class"); end
        n_checks++; if (ready1_bad) begin n_fail++; $display("FAIL stall_lane1_ready: got 1 want 0 while busy"); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL back_to_back_accept: got %b want 10", req_ready); end
        stub_probs = rand_vec();
        step();
        req_valid = '0;
        n = 0;
        while (n < 1000 && !rsp_valid[1]) begin
            step();
            n++;
        end
        n_checks++; if (rsp_valid !== 2'b10 || rsp_class !== 4'(ref_argmax(stub_probs))) begin
            n_fail++; $display("FAIL back_to_back_rsp: valid %b class %0d want 10 class %0d", rsp_valid, rsp_class, ref_argmax(stub_probs)); end
        rsp_ready = 2'b10;
        step();
        rsp_ready = '0;
        rr_last = 1;
    endtask

    task automatic test_random();
        logic [VW-1:0] lg, pr;
        int ta, tr, lane;
        logic [3:0] cls;
        logic err;
        bit ok;
        for (int j = 0; j < 6; j++) begin
            lane = $urandom_range(0, NUM_REQ - 1);
            lg = rand_vec();
            stub_probs = rand_vec();
            if (j % 2 == 1) stub_probs[9*DW +: DW] = stub_probs[4*DW +: DW];
            stub_lat = $urandom_range(2, 60);
            run_job(lane, lg, ta, tr, pr, cls, err, ok);
            n_checks++; if (!ok || pr !== stub_probs || err !== 1'b0) begin
                n_fail++; $display("FAIL random_%0d_rsp: ok %b probs %h err %b want probs %h err 0", j, ok, pr, err, stub_probs); end
            n_checks++; if (cls !== 4'(ref_argmax(stub_probs))) begin n_fail++; $display("FAIL random_%0d_class: got %0d want %0d", j, cls, ref_argmax(stub_probs)); end
            n_checks++; if (sm_logits !== lg || tr !== w_cyc + LANES + 1) begin
                n_fail++; $display("FAIL random_%0d_capture_timing: logits %h rsp@%0d want %h rsp@%0d", j, sm_logits, tr, lg, w_cyc + LANES + 1); end
            rr_last = lane;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit lane1_rsp;
        stub_lat = 46;
        stub_probs = rand_vec();
        req_logits[VW +: VW] = rand_vec();
        req_valid = 2'b10;
        n = 0;
        while (n < 200) begin
            #1;
            if (req_ready[1]) break;
            step();
            n++;
        end
        step();
        req_valid = '0;
        repeat (6) step();
        req_valid = 2'b11;
        rst = 1'b1;
        step();
        n_checks++; if (rsp_valid !== '0 || req_ready !== '0 || sm_in_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_control: rsp_valid %b req_ready %b in_valid %b want 0", rsp_valid, req_ready, sm_in_valid); end
        n_checks++; if (rsp_probs !== '0 || rsp_class !== 4'd0 || rsp_err !== 1'b0 || sm_logits !== '0) begin
            n_fail++; $display("FAIL midrst_data: probs %h class %h err %b logits %h want zeros", rsp_probs, rsp_class, rsp_err, sm_logits); end
        n_checks++; if (sm_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_sm_rst: got %b want 1", sm_rst); end
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 01", req_ready); end
        step();
        req_valid = '0;
        lane1_rsp = 1'b0;
        n = 0;
        while (n < 1000 && rsp_valid == '0) begin
            step();
            n++;
        end
        if (rsp_valid[1]) lane1_rsp = 1'b1;
        n_checks++; if (lane1_rsp || rsp_valid !== 2'b01) begin n_fail++; $display("FAIL midrst_resume: got %b want 01", rsp_valid); end
        rsp_ready = 2'b01;
        step();
        rsp_ready = '0;
        rr_last = 0;
    endtask

`ifdef SOFTMAX_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        logic [VW-1:0] pr;
        int ta, tr;
        logic [3:0] cls;
        logic err;
        bit ok;
        stub_lat = 0;
        stub_probs = rand_vec();
        run_job(0, rand_vec(), ta, tr, pr, cls, err, ok);
        n_checks++; if (!ok || tr !== launch_cyc + 1 + TIMEOUT) begin
            n_fail++; $display("FAIL wd_timing: ok %b rsp@%0d want rsp@%0d", ok, tr, launch_cyc + 1 + TIMEOUT); end
        n_checks++; if (err !== 1'b1 || cls !== 4'hF || pr !== '0) begin
            n_fail++; $display("FAIL wd_payload: err %b class %h probs %h want 1 F 0", err, cls, pr); end
        stub_lat = 20;
        run_job(1, rand_vec(), ta, tr, pr, cls, err, ok);
        n_checks++; if (!ok || err !== 1'b0 || cls !== 4'(ref_argmax(stub_probs))) begin
            n_fail++; $display("FAIL wd_recover: ok %b err %b class %0d want err 0 class %0d", ok, err, cls, ref_argmax(stub_probs)); end
    endtask
`else
    task automatic test_watchdog();
        bit seen;
        int n;
        stub_lat = 0;
        req_logits[0 +: VW] = rand_vec();
        req_valid = 2'b01;
        n = 0;
        while (n < 200) begin
            #1;
            if (req_ready[0]) break;
            step();
            n++;
        end
        step();
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 3 * TIMEOUT; c++) begin
            if (rsp_valid !== '0 || rsp_err !== 1'b0) seen = 1'b1;
            step();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL nowd_wait: got response/err while unit stalled want none"); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        rr_last = NUM_REQ - 1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_logits = '0;
        stub_probs = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_tie();
        test_stall_back_to_back();
        test_random();
        test_reset_mid();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
